// File: rtl/lb_rd_proc_pkg.sv
// Shared definitions for the line-buffer read path: controller read FSM states,
// RAM select masks and the line-ordering record.
package lb_rd_proc_pkg;

  typedef enum logic [2:0] {
    RdIdle     = 3'd0,
    RdBuffer1  = 3'd1,
    RdBuffer2  = 3'd2,
    RdBuffer3  = 3'd3,
    RdBuffer4  = 3'd4,
    RdActive   = 3'd5,
    RdFlush    = 3'd6,
    RdLast     = 3'd7
  } rd_state_e;

  // Three-line masks (oldest, center, newest)
  localparam logic [3:0] SelMaskE = 4'hE;
  localparam logic [3:0] SelMaskD = 4'hD;
  localparam logic [3:0] SelMaskB = 4'hB;
  localparam logic [3:0] SelMask7 = 4'h7;
  // Two-line masks (oldest, newest)
  localparam logic [3:0] SelMask3 = 4'h3;
  localparam logic [3:0] SelMask6 = 4'h6;
  localparam logic [3:0] SelMaskC = 4'hC;
  localparam logic [3:0] SelMask9 = 4'h9;

  typedef struct packed {
    logic [1:0] oldest;
    logic [1:0] center;
    logic [1:0] newest;
    logic [2:0] count;
  } line_order_t;

  function automatic line_order_t mk_order(input logic [1:0] oldest, input logic [1:0] center,
                                           input logic [1:0] newest, input logic [2:0] count);
    line_order_t o;
    o.oldest = oldest;
    o.center = center;
    o.newest = newest;
    o.count  = count;
    return o;
  endfunction

endpackage

// File: rtl/lb_rd_proc_line_order.sv
// Maps a RAM select mask to zero-based RAM indices in age order plus the number
// of contributing lines; unlisted masks report a count of zero.
module lb_line_order
  import lb_rd_proc_pkg::*;
(
  input  logic [3:0]  sel,
  output line_order_t order
);

  always_comb begin
    order = '0;
    case (sel)
      SelMaskE: order = mk_order(2'd1, 2'd2, 2'd3, 3'd3);
      SelMaskD: order = mk_order(2'd2, 2'd3, 2'd0, 3'd3);
      SelMaskB: order = mk_order(2'd3, 2'd0, 2'd1, 3'd3);
      SelMask7: order = mk_order(2'd0, 2'd1, 2'd2, 3'd3);
      SelMask3: order = mk_order(2'd0, 2'd0, 2'd1, 3'd2);
      SelMask6: order = mk_order(2'd1, 2'd1, 2'd2, 3'd2);
      SelMaskC: order = mk_order(2'd2, 2'd2, 2'd3, 3'd2);
      SelMask9: order = mk_order(2'd3, 2'd3, 2'd0, 3'd2);
      4'h1:     order = mk_order(2'd0, 2'd0, 2'd0, 3'd1);
      4'h2:     order = mk_order(2'd1, 2'd1, 2'd1, 3'd1);
      4'h4:     order = mk_order(2'd2, 2'd2, 2'd2, 3'd1);
      4'h8:     order = mk_order(2'd3, 2'd3, 2'd3, 3'd1);
      default:  order = '0;
    endcase
  end

endmodule

// File: rtl/lb_rd_proc.sv
// Read-side consumer of the four line RAMs: aligns controller strobes to RAM
// latency, applies vertical blur or pass-through and regenerates sync timing.
module lb_rd_proc
  import lb_rd_proc_pkg::*;
#(
  parameter int unsigned PARAM_WIDTH = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned RAM_LAT     = 1,
  parameter int unsigned HS_WIDTH    = 44,
  parameter int unsigned VS_WIDTH    = 5
) (
  input  logic                   I_CLK,
  input  logic                   I_RSTN,
  input  logic [3:0]             i_sel,
  input  logic                   i_den,
  input  logic [PARAM_WIDTH-1:0] i_vact_state,
  input  logic [DATA_WIDTH-1:0]  i_dout1,
  input  logic [DATA_WIDTH-1:0]  i_dout2,
  input  logic [DATA_WIDTH-1:0]  i_dout3,
  input  logic [DATA_WIDTH-1:0]  i_dout4,
  input  logic                   i_blur_mode_cap,
  input  logic                   i_mirror_mode_cap,
  output logic                   o_vsync,
  output logic                   o_hsync,
  output logic                   o_den,
  output logic [DATA_WIDTH-1:0]  o_data
);

  localparam int unsigned SumW = DATA_WIDTH + 2;
  localparam logic [PARAM_WIDTH-1:0] CntOne = PARAM_WIDTH'(1);

  // Mirroring is handled by upstream addressing; the flag is carried for visibility only.
  logic unused_mirror;
  assign unused_mirror = i_mirror_mode_cap;

  logic [DATA_WIDTH-1:0] dout [4];
  assign dout[0] = i_dout1;
  assign dout[1] = i_dout2;
  assign dout[2] = i_dout3;
  assign dout[3] = i_dout4;

  logic [3:0]         sel_pipe [RAM_LAT];
  logic [RAM_LAT-1:0] den_pipe;
  logic [3:0]         sel_a;
  logic               den_a;
  assign sel_a = sel_pipe[RAM_LAT-1];
  assign den_a = den_pipe[RAM_LAT-1];

  logic             vact_busy;
  logic             frame_start;
  logic             blur_frame;
  logic [RAM_LAT:0] fs_pipe;
  assign frame_start = (i_vact_state != PARAM_WIDTH'(RdIdle)) && !vact_busy;

  line_order_t order;
  lb_line_order u_line_order (
    .sel   (sel_a),
    .order (order)
  );

  logic [DATA_WIDTH-1:0]  op_old, op_ctr, op_new;
  logic [2:0]             op_cnt;
  logic                   op_blur;
  logic                   den_s1;
  logic                   den_prev;
  logic [PARAM_WIDTH-1:0] hs_cnt, vs_cnt;
  logic [SumW-1:0]        sum3, sum2;
  logic [DATA_WIDTH-1:0]  pix;

  always_ff @(posedge I_CLK) begin
    if (!I_RSTN) begin
      for (int i = 0; i < RAM_LAT; i++) sel_pipe[i] <= '0;
      den_pipe   <= '0;
      vact_busy  <= 1'b0;
      blur_frame <= 1'b0;
      fs_pipe    <= '0;
    end else begin
      sel_pipe[0] <= i_sel;
      den_pipe[0] <= i_den;
      for (int i = 1; i < RAM_LAT; i++) begin
        sel_pipe[i] <= sel_pipe[i-1];
        den_pipe[i] <= den_pipe[i-1];
      end
      vact_busy <= (i_vact_state != PARAM_WIDTH'(RdIdle));
      if (frame_start) blur_frame <= i_blur_mode_cap;
      fs_pipe <= {fs_pipe[RAM_LAT-1:0], frame_start};
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RSTN) begin
      op_old  <= '0;
      op_ctr  <= '0;
      op_new  <= '0;
      op_cnt  <= '0;
      op_blur <= 1'b0;
      den_s1  <= 1'b0;
    end else begin
      op_old  <= dout[order.oldest];
      op_ctr  <= dout[order.center];
      op_new  <= dout[order.newest];
      op_cnt  <= order.count;
      op_blur <= blur_frame;
      den_s1  <= den_a;
    end
  end

  always_comb begin
    sum3 = {2'b00, op_old} + {1'b0, op_ctr, 1'b0} + {2'b00, op_new} + SumW'(2);
    sum2 = {2'b00, op_old} + {2'b00, op_new} + SumW'(1);
    pix  = '0;
    case (op_cnt)
      3'd3:    pix = op_blur ? DATA_WIDTH'(sum3 >> 2) : op_ctr;
      3'd2:    pix = op_blur ? DATA_WIDTH'(sum2 >> 1) : op_old;
      3'd1:    pix = op_old;
      default: pix = '0;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RSTN) begin
      o_den    <= 1'b0;
      o_data   <= '0;
      den_prev <= 1'b0;
      hs_cnt   <= '0;
      vs_cnt   <= '0;
    end else begin
      o_den    <= den_s1;
      o_data   <= den_s1 ? pix : '0;
      den_prev <= o_den;
      // den_s1 is next cycle's o_den, so hsync never overlaps active data.
      if (den_s1) hs_cnt <= '0;
      else if (den_prev && !o_den) hs_cnt <= PARAM_WIDTH'(HS_WIDTH);
      else if (hs_cnt != '0) hs_cnt <= hs_cnt - CntOne;
      if (fs_pipe[RAM_LAT]) vs_cnt <= PARAM_WIDTH'(VS_WIDTH);
      else if (vs_cnt != '0) vs_cnt <= vs_cnt - CntOne;
    end
  end

  assign o_hsync = (hs_cnt != '0);
  assign o_vsync = (vs_cnt != '0);

endmodule

// File: tb/tb_lb_rd_proc.sv
// Randomised scoreboard bench for lb_rd_proc against a behavioural reference model.
module tb_lb_rd_proc;

  localparam int PW   = 16;
  localparam int DW   = 8;
  localparam int LAT  = 1;
  localparam int HS   = 44;
  localparam int VS   = 5;
  localparam int HIST = 8192;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic          den = 1'b0;
  logic [PW-1:0] vact = '0;
  logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic          blur = 1'b0;
  logic          mirror = 1'b0;
  logic          vs_o, hs_o, den_o;
  logic [DW-1:0] data_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lb_rd_proc #(
    .PARAM_WIDTH (PW),
    .DATA_WIDTH  (DW),
    .RAM_LAT     (LAT),
    .HS_WIDTH    (HS),
    .VS_WIDTH    (VS)
  ) dut (
    .I_CLK             (clk),
    .I_RSTN            (rstn),
    .i_sel             (sel),
    .i_den             (den),
    .i_vact_state      (vact),
    .i_dout1           (d1),
    .i_dout2           (d2),
    .i_dout3           (d3),
    .i_dout4           (d4),
    .i_blur_mode_cap   (blur),
    .i_mirror_mode_cap (mirror),
    .o_vsync           (vs_o),
    .o_hsync           (hs_o),
    .o_den             (den_o),
    .o_data            (data_o)
  );

  typedef struct {
    int         due;
    bit         den;
    logic [7:0] data;
    bit         hs;
    bit         vs;
  } exp_t;

  exp_t        exp_q[$];
  int          fs_q[$];
  logic [3:0]  sel_h [HIST];
  bit          den_h [HIST];
  logic [31:0] dreq_h [HIST];
  int          rst_floor = -1;
  int          last_fall = -1000000;
  bit          prev_out_den = 1'b0;
  bit          vact_nz_prev = 1'b0;
  bit          model_blur = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [3:0] all_masks [14] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'h3, 4'h6, 4'hC, 4'h9,
                                 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'hF};

  function automatic logic [3:0] rand_mask();
    return all_masks[$urandom_range(0, 13)];
  endfunction

  // Reference pixel: lines are taken cyclically starting after the cleared bit(s).
  function automatic logic [7:0] ref_pixel(input logic [3:0] m, input logic [31:0] dv,
                                           input bit bl);
    int n;
    int first;
    int v[3];
    n = $countones(m);
    if (n == 0 || n == 4) return 8'd0;
    first = 0;
    for (int i = 0; i < 4; i++) if (m[i] && !m[(i + 3) % 4]) first = i;
    for (int k = 0; k < 3; k++) v[k] = int'(dv[8 * ((first + k) % 4) +: 8]);
    if (n == 3) return bl ? 8'((v[0] + 2 * v[1] + v[2] + 2) / 4) : 8'(v[1]);
    if (n == 2) return bl ? 8'((v[0] + v[1] + 1) / 2) : 8'(v[0]);
    return 8'(v[0]);
  endfunction

  task automatic push_zero(input int due);
    exp_t e;
    e.due = due; e.den = 1'b0; e.data = 8'd0; e.hs = 1'b0; e.vs = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic model_reset(input int r);
    while (exp_q.size() > 0 && exp_q[$].due > r) void'(exp_q.pop_back());
    push_zero(r + 1);
    push_zero(r + 2);
    rst_floor    = r;
    last_fall    = -1000000;
    prev_out_den = 1'b0;
    vact_nz_prev = 1'b0;
    model_blur   = 1'b0;
    fs_q.delete();
  endtask

  task automatic model_cycle(input int n, input int va, input logic [3:0] s, input bit de,
                             input bit bl, input logic [31:0] dc);
    logic [3:0] sa;
    bit         da;
    bit         fs;
    bit         vsx;
    exp_t       e;
    int         c;
    sa = 4'h0;
    da = 1'b0;
    if (n - LAT > rst_floor) begin
      sa = sel_h[n - LAT];
      da = den_h[n - LAT];
    end
    c = n + 2;
    e.due  = c;
    e.den  = da;
    e.data = da ? ref_pixel(sa, dc, model_blur) : 8'd0;
    if (prev_out_den && !da) last_fall = c;
    e.hs = !da && (c - last_fall >= 1) && (c - last_fall <= HS);
    fs = (va != 0) && !vact_nz_prev;
    if (fs) fs_q.push_back(n);
    while (fs_q.size() > 0 && fs_q[0] <= n - LAT - VS) void'(fs_q.pop_front());
    vsx = 1'b0;
    foreach (fs_q[i]) if (fs_q[i] > n - LAT - VS && fs_q[i] <= n - LAT) vsx = 1'b1;
    e.vs = vsx;
    exp_q.push_back(e);
    prev_out_den = da;
    if (fs) model_blur = bl;
    vact_nz_prev = (va != 0);
    sel_h[n] = s;
    den_h[n] = de;
  endtask

  // One clock of stimulus; dv is the RAM data that answers this cycle's select.
  task automatic step(input bit r, input int va, input logic [3:0] s, input bit de,
                      input bit bl, input logic [31:0] dv);
    int          n;
    logic [31:0] dc;
    @(posedge clk);
    #1;
    n = cyc;
    rstn   = r;
    vact   = PW'(va);
    sel    = s;
    den    = de;
    blur   = bl;
    mirror = 1'($urandom_range(0, 1));
    dreq_h[n] = dv;
    dc = (n >= LAT) ? dreq_h[n - LAT] : $urandom;
    {d4, d3, d2, d1} = dc;
    if (!r) model_reset(n);
    else model_cycle(n, va, s, de, bl, dc);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("den", {31'b0, den_o}, {31'b0, e.den});
        check("data", {24'b0, data_o}, {24'b0, e.data});
        check("hsync", {31'b0, hs_o}, {31'b0, e.hs});
        check("vsync", {31'b0, vs_o}, {31'b0, e.vs});
      end
    end
  end

  initial begin
    int va;
    repeat (3) step(1'b0, 0, 4'h0, 1'b0, 1'b0, $urandom);
    repeat (4) step(1'b1, 0, 4'h0, 1'b0, 1'b1, $urandom);

    // Frame 1, blur captured on: directed pixels then blur toggling mid-frame.
    step(1'b1, 1, 4'hE, 1'b1, 1'b1, {8'd40, 8'd20, 8'd10, 8'd0});
    step(1'b1, 1, 4'h9, 1'b1, 1'b0, {8'd255, 8'd0, 8'd0, 8'd0});
    step(1'b1, 1, 4'h0, 1'b1, 1'b0, $urandom);
    step(1'b1, 1, 4'hF, 1'b1, 1'b0, $urandom);
    step(1'b1, 1, 4'h4, 1'b1, 1'b0, $urandom);
    step(1'b1, 1, 4'hC, 1'b1, 1'b0, $urandom);
    for (int k = 0; k < 30; k++) step(1'b1, 1, rand_mask(), 1'b1, 1'($urandom_range(0, 1)), $urandom);
    repeat (6) step(1'b1, 0, 4'h0, 1'b0, 1'b0, $urandom);

    // Frame 2, blur captured off.
    step(1'b1, 2, 4'hD, 1'b1, 1'b0, $urandom);
    step(1'b1, 2, 4'h7, 1'b1, 1'b1, $urandom);
    for (int k = 0; k < 20; k++) step(1'b1, 2, rand_mask(), 1'b1, 1'b1, $urandom);

    // Random bursts with frequent frame starts, including restarts inside a vsync pulse.
    va = 3;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) va = (va == 0) ? int'($urandom_range(1, 7)) : 0;
      step(1'b1, va, rand_mask(), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           $urandom);
    end
    step(1'b1, 0, 4'h0, 1'b0, 1'b0, $urandom);
    step(1'b1, 5, 4'h0, 1'b0, 1'b1, $urandom);
    step(1'b1, 0, 4'h0, 1'b0, 1'b1, $urandom);
    step(1'b1, 5, 4'h0, 1'b0, 1'b1, $urandom);

    // One full video line: 1920 active, 280 blank.
    for (int k = 0; k < 1920; k++) step(1'b1, 5, rand_mask(), 1'b1, 1'b0, $urandom);
    for (int k = 0; k < 280; k++) step(1'b1, 5, rand_mask(), 1'b0, 1'b0, $urandom);

    // Reset in the middle of active data, then a clean new frame.
    for (int k = 0; k < 10; k++) step(1'b1, 5, rand_mask(), 1'b1, 1'b0, $urandom);
    step(1'b0, 0, rand_mask(), 1'b1, 1'b0, $urandom);
    repeat (4) step(1'b1, 0, rand_mask(), 1'b0, 1'b1, $urandom);
    step(1'b1, 1, 4'hE, 1'b1, 1'b1, {8'd40, 8'd20, 8'd10, 8'd0});
    for (int k = 0; k < 20; k++) step(1'b1, 1, rand_mask(), 1'b1, 1'b0, $urandom);
    repeat (60) step(1'b1, 0, 4'h0, 1'b0, 1'b0, $urandom);

    repeat (3) @(negedge clk);
    if (n_cmp == 0) begin
      n_bad++;
      $display("FAIL no_comparisons: got 0 compared, want > 0");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
